// File: rtl/tile_sequencer.sv
// tile_sequencer: falling-tile rhythm game controller that moves four lane tiles,
// scores key hits inside a y window and hands each frame to an external drawer.
module tile_sequencer #(
    parameter logic [27:0] TICK_LOAD = 28'd12499999,
    parameter int          TILE_STEP = 8,
    parameter int          HIT_Y_MIN = 96,
    parameter int          HIT_Y_MAX = 111
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic       start,
    input  logic [3:0] keys,
    input  logic       done,
    output logic       go,
    output logic [7:0] x1,
    output logic [7:0] x2,
    output logic [7:0] x3,
    output logic [7:0] x4,
    output logic [7:0] y1,
    output logic [7:0] y2,
    output logic [7:0] y3,
    output logic [7:0] y4,
    output logic       gd,
    output logic [7:0] score,
    output logic [3:0] ledr
);
    localparam logic [7:0] Y_MIN = 8'(HIT_Y_MIN);
    localparam logic [7:0] Y_MAX = 8'(HIT_Y_MAX);
    localparam logic [7:0] STEP  = 8'(TILE_STEP);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, MOVE, GO, WAIT_DONE, OVER} state_t;

    state_t          state_q, state_d;
    logic [3:0][1:0] lane_q, lane_d;
    logic [3:0][7:0] y_q, y_d, y_mv;
    logic [7:0]      score_q, score_d, lfsr_q, best;
    logic [3:0]      ledr_q, ledr_d, pend_q, pend_d, keys_q, key_edge;
    logic [27:0]     cnt_q, cnt_d;
    logic            tick_q, tick_d, start_q, start_edge, play, single, found, miss;
    logic [1:0]      win;

    function automatic logic [7:0] lane_x(input logic [1:0] lane);
        return 8'(lane) * 8'd40;
    endfunction

    assign start_edge = start & ~start_q;
    assign key_edge   = keys & ~keys_q;
    assign play       = state_q inside {WAIT_TICK, MOVE, GO, WAIT_DONE};
    assign single     = (pend_q != 4'd0) && ((pend_q & (pend_q - 4'd1)) == 4'd0);

    // Hit candidate: lane matches the pressed key, y in window, largest y, lowest index on tie
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        best  = 8'd0;
        miss  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            y_mv[i] = y_q[i] + STEP;
            miss    = miss | (y_mv[i] > Y_MAX);
            if (pend_q[lane_q[i]] && y_q[i] >= Y_MIN && y_q[i] <= Y_MAX && (!found || y_q[i] > best)) begin
                found = 1'b1;
                win   = 2'(i);
                best  = y_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        y_d     = y_q;
        score_d = score_q;
        ledr_d  = ledr_q;
        pend_d  = play ? (pend_q | key_edge) : 4'd0;
        cnt_d   = !play ? cnt_q : (cnt_q == 28'd0 ? TICK_LOAD : cnt_q - 28'd1);
        tick_d  = tick_q | (play && cnt_q == 28'd0);
        unique case (state_q)
            IDLE, OVER: if (start_edge) begin
                lane_d  = {2'd1, 2'd3, 2'd0, 2'd2};
                y_d     = {8'd96, 8'd64, 8'd32, 8'd0};
                score_d = 8'd0;
                ledr_d  = 4'd0;
                cnt_d   = TICK_LOAD;
                pend_d  = 4'd0;
                tick_d  = 1'b0;
                state_d = GO;
            end
            GO:        state_d = WAIT_DONE;
            WAIT_DONE: state_d = done ? WAIT_TICK : WAIT_DONE;
            WAIT_TICK: if (pend_q != 4'd0) begin
                pend_d = key_edge;
                if (single && found) begin
                    y_d[win]    = 8'd0;
                    lane_d[win] = lfsr_q[1:0];
                    score_d     = score_q + {7'd0, score_q != 8'hFF};
                    ledr_d      = pend_q;
                    state_d     = GO;
                end else begin
                    state_d = OVER;
                end
            end else if (tick_q) begin
                tick_d  = cnt_q == 28'd0;
                state_d = MOVE;
            end
            MOVE: begin
                y_d     = y_mv;
                state_d = miss ? OVER : GO;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state_q <= IDLE;
            lane_q  <= '0;
            y_q     <= '0;
            score_q <= 8'd0;
            ledr_q  <= 4'd0;
            pend_q  <= 4'd0;
            tick_q  <= 1'b0;
            cnt_q   <= TICK_LOAD;
            lfsr_q  <= 8'hA5;
            start_q <= 1'b0;
            keys_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            y_q     <= y_d;
            score_q <= score_d;
            ledr_q  <= ledr_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            start_q <= start;
            keys_q  <= keys;
        end
    end

    assign go    = state_q == GO;
    assign gd    = state_q == OVER;
    assign score = score_q;
    assign ledr  = ledr_q;
    assign x1    = lane_x(lane_q[0]);
    assign x2    = lane_x(lane_q[1]);
    assign x3    = lane_x(lane_q[2]);
    assign x4    = lane_x(lane_q[3]);
    assign y1    = y_q[0];
    assign y2    = y_q[1];
    assign y3    = y_q[2];
    assign y4    = y_q[3];
endmodule

// File: tb/tb_tile_sequencer.sv
// tb_tile_sequencer: directed checks of start, frame handshake, scrolling, hits, misses and reset
// with a fast tick (TICK_LOAD=3) and an independent LFSR model for respawn lanes.
module tb_tile_sequencer;
    logic       clock = 1'b0, clear_b = 1'b0, start = 1'b0, done = 1'b0;
    logic [3:0] keys = 4'd0;
    logic       go, gd;
    logic [7:0] x1, x2, x3, x4, y1, y2, y3, y4, score;
    logic [3:0] ledr;
    int         checks = 0, failures = 0, go_cnt = 0;
    logic [7:0] m_lfsr, m_old, last_score = 8'd0;
    logic [1:0] hit_lane [256];

    tile_sequencer #(.TICK_LOAD(28'd3)) dut (
        .clock(clock), .clear_b(clear_b), .start(start), .keys(keys), .done(done),
        .go(go), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .gd(gd), .score(score), .ledr(ledr)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            m_lfsr <= 8'hA5;
            m_old  <= 8'hA5;
        end else begin
            m_old  <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // m_old is the LFSR value the design saw at the edge that just scored
    always @(negedge clock) begin
        if (go) go_cnt++;
        if (score != last_score) hit_lane[score] = m_old[1:0];
        last_score = score;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (!go && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(go), 32'd1);
    endtask

    task automatic wait_gd(input string tag);
        int n = 0;
        while (!gd && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(gd), 32'd1);
    endtask

    task automatic wait_score(input string tag, input logic [7:0] v);
        int n = 0;
        while (score != v && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(score), 32'(v));
    endtask

    task automatic ack(input logic [3:0] k);
        tick();
        keys = k;
        done = 1'b1;
        tick();
        done = 1'b0;
        keys = 4'd0;
    endtask

    task automatic restart();
        clear_b = 1'b0;
        start   = 1'b0;
        keys    = 4'd0;
        done    = 1'b0;
        tick();
        clear_b = 1'b1;
        tick();
        start = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int g, n;
        logic [3:0] kk;
        logic [1:0] lanes [3];
        lanes = '{2'd3, 2'd0, 2'd2};
        tick(2);
        check("rst_go", 32'(go), 0);
        check("rst_gd", 32'(gd), 0);
        check("rst_score", 32'(score), 0);
        check("rst_ledr", 32'(ledr), 0);
        check("rst_xy", {x1, x2, x3, x4} | {y1, y2, y3, y4}, 0);
        clear_b = 1'b1;
        tick();
        g = go_cnt;
        start = 1'b1;
        n = 0;
        while (!go && n < 3) begin
            tick();
            n++;
        end
        check("start_go_3cyc", 32'(go), 1);
        check("init_x", {x1, x2, x3, x4}, 32'h50007828);
        check("init_y", {y1, y2, y3, y4}, 32'h00204060);
        tick(20);
        check("no_done_one_go", 32'(go_cnt - g), 1);
        check("no_done_y_frozen", {y1, y2, y3, y4}, 32'h00204060);
        check("no_done_gd", 32'(gd), 0);

        restart();
        wait_go("scroll_go0");
        ack(4'd0);
        wait_go("scroll_go1");
        check("scroll_y1", {y1, y2, y3, y4}, 32'h08284868);
        g = go_cnt;
        ack(4'd0);
        wait_gd("miss_gd");
        check("miss_y4", 32'(y4), 112);
        tick(10);
        check("miss_no_go", 32'(go_cnt - g), 0);
        check("miss_go_low", 32'(go), 0);

        restart();
        wait_go("hit_go0");
        g = go_cnt;
        ack(4'b0010);
        wait_score("hit_score", 8'd1);
        check("hit_ledr", 32'(ledr), 32'b0010);
        check("hit_y4", 32'(y4), 0);
        check("hit_x4", 32'(x4), 32'(hit_lane[1]) * 40);
        tick(10);
        check("hit_one_go", 32'(go_cnt - g), 1);
        check("hit_gd", 32'(gd), 0);

        restart();
        wait_go("wrong_go0");
        g = go_cnt;
        ack(4'b0001);
        wait_gd("wrong_gd");
        check("wrong_score", 32'(score), 0);
        tick(8);
        check("wrong_no_go", 32'(go_cnt - g), 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        wait_go("regame_go");
        check("regame_gd", 32'(gd), 0);
        check("regame_y", {y1, y2, y3, y4}, 32'h00204060);
        check("regame_x", {x1, x2, x3, x4}, 32'h50007828);

        restart();
        wait_go("multi_go0");
        ack(4'b1010);
        wait_gd("multi_gd");
        check("multi_score", 32'(score), 0);

        restart();
        wait_go("early_go0");
        tick();
        keys = 4'b0010;
        tick(6);
        check("early_score_held", 32'(score), 0);
        check("early_gd", 32'(gd), 0);
        check("early_y_frozen", {y1, y2, y3, y4}, 32'h00204060);
        done = 1'b1;
        tick();
        done = 1'b0;
        keys = 4'd0;
        wait_score("early_after_done", 8'd1);
        check("early_ledr", 32'(ledr), 32'b0010);

        restart();
        wait_go("five_go0");
        ack(4'b0010);
        for (int h = 0; h < 3; h++) begin
            repeat (4) begin
                wait_go("five_go");
                ack(4'd0);
            end
            wait_go("five_go_key");
            kk = 4'b0001 << lanes[h];
            ack(kk);
        end
        wait_go("five_go_last");
        kk = 4'b0001 << hit_lane[1];
        ack(kk);
        wait_go("five_go_final");
        tick();
        check("five_score", 32'(score), 5);
        check("five_gd", 32'(gd), 0);
        start   = 1'b0;
        clear_b = 1'b0;
        #1;
        check("midrst_go", 32'(go), 0);
        check("midrst_gd", 32'(gd), 0);
        check("midrst_score", 32'(score), 0);
        check("midrst_x", {x1, x2, x3, x4}, 0);
        check("midrst_y", {y1, y2, y3, y4}, 0);
        tick();
        clear_b = 1'b1;
        g = go_cnt;
        tick(10);
        check("midrst_idle", 32'(go_cnt - g), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
